// File: rtl/snn_pkg.sv
// Shared widths, FSM state encoding and the saturating adder used by the
// synaptic accumulation unit and its helpers.
package snn_pkg;

    localparam int SNN_ADDR_W   = 12;
    localparam int SNN_WEIGHT_W = 16;
    localparam int SNN_ACC_W    = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Signed add of two sign-extended operands, clamped to an acc_w-bit
    // two's-complement range. Operands are carried at 64 bits so the raw sum
    // can never wrap before the clamp is applied.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 acc_w
    );
        logic signed [63:0] sum;
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        sum  = a + b;
        maxv = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        minv = -maxv - 64'sd1;
        if (sum > maxv) begin
            sat_add = maxv;
        end else if (sum < minv) begin
            sat_add = minv;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/syn_match_cam.sv
// Parallel source-address comparator: flags every enabled table entry whose
// address equals the incoming spike address.
module syn_match_cam
    import snn_pkg::*;
#(
    parameter int NUM_CONN = 8,
    parameter int ADDR_W   = SNN_ADDR_W
) (
    input  logic [ADDR_W-1:0]   i_tbl_addr [NUM_CONN],
    input  logic [NUM_CONN-1:0] i_tbl_en,
    input  logic [ADDR_W-1:0]   i_spike_addr,
    input  logic                i_spike_valid,
    output logic [NUM_CONN-1:0] o_match
);

    // Compare against every entry at once; disabled entries never match.
    always_comb begin
        o_match = '0;
        for (int i = 0; i < NUM_CONN; i++) begin
            o_match[i] = i_spike_valid && i_tbl_en[i] && (i_tbl_addr[i] == i_spike_addr);
        end
    end

endmodule

// File: rtl/syn_accum_unit.sv
// Synaptic accumulation unit for one neuron: programmable connection table,
// per-timestep spike capture, sequential saturating weight accumulation and a
// valid/ready result port toward the LIF stage.
module syn_accum_unit
    import snn_pkg::*;
#(
    parameter  int NUM_CONN = 8,
    parameter  int ADDR_W   = SNN_ADDR_W,
    parameter  int WEIGHT_W = SNN_WEIGHT_W,
    parameter  int ACC_W    = SNN_ACC_W,
    localparam int IDX_W    = $clog2(NUM_CONN)
) (
    input  logic                CLK_Mac,
    input  logic                RST_Mac,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [ADDR_W-1:0]   cfg_src_addr,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    input  logic                cfg_en,
    output logic                cfg_err,
    input  logic                spike_valid,
    input  logic [ADDR_W-1:0]   spike_addr,
    output logic                spike_hit,
    output logic                spike_miss,
    input  logic                timestep_end,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_sum,
    output logic [NUM_CONN-1:0] out_spike_map,
    output logic                busy,
    output logic                overrun
);

    logic [ADDR_W-1:0]          r_tbl_addr   [NUM_CONN];
    logic signed [WEIGHT_W-1:0] r_tbl_weight [NUM_CONN];
    logic [NUM_CONN-1:0]        r_tbl_en;
    logic [NUM_CONN-1:0]        r_incoming_map;
    logic [NUM_CONN-1:0]        r_pending_map;
    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_cfg_err;
    logic                       r_spike_hit;
    logic                       r_spike_miss;
    logic                       r_overrun;

    logic [NUM_CONN-1:0]        w_match;
    logic                       w_idx_ok;
    logic                       w_cfg_write;
    logic                       w_ts_accept;
    logic signed [63:0]         w_sat;
    logic                       w_unused_sat_hi;

    syn_match_cam #(
        .NUM_CONN (NUM_CONN),
        .ADDR_W   (ADDR_W)
    ) u_cam (
        .i_tbl_addr    (r_tbl_addr),
        .i_tbl_en      (r_tbl_en),
        .i_spike_addr  (spike_addr),
        .i_spike_valid (spike_valid),
        .o_match       (w_match)
    );

    assign w_idx_ok    = (32'(cfg_idx) < NUM_CONN);
    assign w_cfg_write = cfg_we && (r_state == ST_IDLE) && w_idx_ok;
    assign w_ts_accept = timestep_end && (r_state == ST_IDLE);

    // The accumulator only ever adds the entry currently addressed by r_idx.
    assign w_sat = sat_add({{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc},
                           {{(64-WEIGHT_W){r_tbl_weight[r_idx][WEIGHT_W-1]}}, r_tbl_weight[r_idx]},
                           ACC_W);
    assign w_unused_sat_hi = ^w_sat[63:ACC_W];

    // Connection table: written only while idle so accumulation always sees the snapshot-time weights.
    always_ff @(posedge CLK_Mac) begin
        if (RST_Mac) begin
            for (int i = 0; i < NUM_CONN; i++) begin
                r_tbl_addr[i]   <= '0;
                r_tbl_weight[i] <= '0;
            end
            r_tbl_en <= '0;
        end else if (w_cfg_write) begin
            r_tbl_addr[cfg_idx]   <= cfg_src_addr;
            r_tbl_weight[cfg_idx] <= cfg_weight;
            r_tbl_en[cfg_idx]     <= cfg_en;
        end
    end

    // Spike maps: accumulate matches all the time, swap into pending only on an accepted timestep close.
    always_ff @(posedge CLK_Mac) begin
        if (RST_Mac) begin
            r_incoming_map <= '0;
            r_pending_map  <= '0;
        end else if (w_ts_accept) begin
            r_pending_map  <= r_incoming_map | w_match;
            r_incoming_map <= '0;
        end else begin
            r_incoming_map <= r_incoming_map | w_match;
        end
    end

    // Control FSM and sequential one-entry-per-cycle accumulation.
    always_ff @(posedge CLK_Mac) begin
        if (RST_Mac) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (timestep_end) begin
                        r_state <= ST_ACCUM;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (r_pending_map[r_idx]) begin
                        r_acc <= w_sat[ACC_W-1:0];
                    end
                    if (r_idx == IDX_W'(NUM_CONN - 1)) begin
                        r_state <= ST_OUT;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One-cycle status pulses reporting what happened on the previous cycle.
    always_ff @(posedge CLK_Mac) begin
        if (RST_Mac) begin
            r_cfg_err    <= 1'b0;
            r_spike_hit  <= 1'b0;
            r_spike_miss <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_cfg_err    <= cfg_we && ((r_state != ST_IDLE) || !w_idx_ok);
            r_spike_hit  <= spike_valid && (|w_match);
            r_spike_miss <= spike_valid && !(|w_match);
            r_overrun    <= timestep_end && (r_state != ST_IDLE);
        end
    end

    assign cfg_err       = r_cfg_err;
    assign spike_hit     = r_spike_hit;
    assign spike_miss    = r_spike_miss;
    assign overrun       = r_overrun;
    assign out_valid     = (r_state == ST_OUT);
    assign busy          = (r_state == ST_ACCUM) || (r_state == ST_OUT);
    assign out_sum       = r_acc;
    assign out_spike_map = r_pending_map;

endmodule

// File: tb/tb_syn_accum_unit.sv
// Directed bench for syn_accum_unit: a default-width instance and an
// ACC_W=16 instance share every input so saturation can be observed.
module tb_syn_accum_unit;

    localparam int NUM_CONN = 8;

    logic        CLK_Mac = 1'b0;
    logic        RST_Mac = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [11:0] cfg_src_addr = '0;
    logic [15:0] cfg_weight = '0;
    logic        cfg_en = 1'b0;
    logic        spike_valid = 1'b0;
    logic [11:0] spike_addr = '0;
    logic        timestep_end = 1'b0;
    logic        out_ready = 1'b0;

    logic        cfg_err, spike_hit, spike_miss, out_valid, busy, overrun;
    logic [23:0] out_sum;
    logic [7:0]  out_spike_map;

    logic        o16_cfg_err, o16_spike_hit, o16_spike_miss, o16_out_valid, o16_busy, o16_overrun;
    logic [15:0] o16_out_sum;
    logic [7:0]  o16_out_spike_map;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [15:0] spikeMask;
        bit          dup;
        int          expSum;
        logic [7:0]  expMap;
    } vec_t;

    vec_t vecs[7];

    syn_accum_unit dut (
        .CLK_Mac(CLK_Mac), .RST_Mac(RST_Mac),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_src_addr(cfg_src_addr),
        .cfg_weight(cfg_weight), .cfg_en(cfg_en), .cfg_err(cfg_err),
        .spike_valid(spike_valid), .spike_addr(spike_addr),
        .spike_hit(spike_hit), .spike_miss(spike_miss),
        .timestep_end(timestep_end), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_spike_map(out_spike_map), .busy(busy), .overrun(overrun)
    );

    syn_accum_unit #(.ACC_W(16)) dut16 (
        .CLK_Mac(CLK_Mac), .RST_Mac(RST_Mac),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_src_addr(cfg_src_addr),
        .cfg_weight(cfg_weight), .cfg_en(cfg_en), .cfg_err(o16_cfg_err),
        .spike_valid(spike_valid), .spike_addr(spike_addr),
        .spike_hit(o16_spike_hit), .spike_miss(o16_spike_miss),
        .timestep_end(timestep_end), .out_valid(o16_out_valid), .out_ready(out_ready),
        .out_sum(o16_out_sum), .out_spike_map(o16_out_spike_map), .busy(o16_busy),
        .overrun(o16_overrun)
    );

    always #5 CLK_Mac = ~CLK_Mac;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge CLK_Mac);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic writeEntry(input int idx, input int addr, input logic [15:0] w, input logic en);
        cfg_we = 1'b1;
        cfg_idx = 3'(idx);
        cfg_src_addr = 12'(addr);
        cfg_weight = w;
        cfg_en = en;
        step();
        cfg_we = 1'b0;
        checkOutput("cfgErrIdle", int'(cfg_err), 0);
    endtask

    task automatic sendSpike(input int addr);
        spike_valid = 1'b1;
        spike_addr = 12'(addr);
        step();
        spike_valid = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        if (!out_valid) checkOutput("validTimeout", 0, 1);
    endtask

    // Close the timestep and check the fixed accumulation latency.
    task automatic closeTimestep(input string name);
        int n;
        timestep_end = 1'b1;
        step();
        timestep_end = 1'b0;
        checkOutput({name, "_busy"}, int'(busy), 1);
        waitValid(n);
        checkOutput({name, "_latency"}, n, NUM_CONN);
    endtask

    task automatic checkResult(input string name, input int exp24, input int exp16, input logic [7:0] expMap);
        checkOutput({name, "_valid"}, int'(out_valid), 1);
        checkOutput({name, "_sum24"}, int'($signed(out_sum)), exp24);
        checkOutput({name, "_sum16"}, int'($signed(o16_out_sum)), exp16);
        checkOutput({name, "_map"}, int'(out_spike_map), int'(expMap));
        checkOutput({name, "_map16"}, int'(o16_out_spike_map), int'(expMap));
    endtask

    task automatic acceptResult(input string name);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput({name, "_validDrop"}, int'(out_valid), 0);
        checkOutput({name, "_busyDrop"}, int'(busy), 0);
    endtask

    task automatic applyStimulus(input vec_t v, input int num);
        string name;
        name = $sformatf("vec%0d", num);
        for (int a = 0; a < 16; a++) begin
            if (v.spikeMask[a]) begin
                sendSpike(a);
                if (v.dup) sendSpike(a);
            end
        end
        closeTimestep(name);
        checkResult(name, v.expSum, v.expSum, v.expMap);
        acceptResult(name);
    endtask

    initial begin
        int n;

        // Entry table: 0:(0,0x0480) 1:(1,0x0130) 2:(2,0x0C40) 3:(7,0x0100)
        // 4:(4,0x1234,disabled) 5:(7,0x0100) 6:(10,-256) 7:(11,1)
        vecs[0] = '{16'h0005, 1'b0, 32'h10C0, 8'h05};
        vecs[1] = '{16'h0080, 1'b1, 32'h0200, 8'h28};
        vecs[2] = '{16'h0000, 1'b0, 0,        8'h00};
        vecs[3] = '{16'h0010, 1'b0, 0,        8'h00};
        vecs[4] = '{16'h0402, 1'b0, 32'h0030, 8'h42};
        vecs[5] = '{16'h0E87, 1'b1, 32'h12F1, 8'hEF};
        vecs[6] = '{16'h0400, 1'b0, -256,     8'h40};

        step();
        step();
        checkOutput("rst_valid", int'(out_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_sum", int'(out_sum), 0);
        checkOutput("rst_map", int'(out_spike_map), 0);
        RST_Mac = 1'b0;
        step();

        writeEntry(0, 0, 16'h0480, 1'b1);
        writeEntry(1, 1, 16'h0130, 1'b1);
        writeEntry(2, 2, 16'h0C40, 1'b1);
        writeEntry(3, 7, 16'h0100, 1'b1);
        writeEntry(4, 4, 16'h1234, 1'b0);
        writeEntry(5, 7, 16'h0100, 1'b1);
        writeEntry(6, 10, 16'hFF00, 1'b1);
        writeEntry(7, 11, 16'h0001, 1'b1);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        // Hit/miss pulses, including a disabled entry and an unknown address.
        sendSpike(7);
        checkOutput("hit7", int'(spike_hit), 1);
        checkOutput("miss7", int'(spike_miss), 0);
        sendSpike(9);
        checkOutput("hit9", int'(spike_hit), 0);
        checkOutput("miss9", int'(spike_miss), 1);
        sendSpike(4);
        checkOutput("missDisabled", int'(spike_miss), 1);
        step();
        checkOutput("hitIdle", int'(spike_hit), 0);
        checkOutput("missIdle", int'(spike_miss), 0);
        closeTimestep("hm");
        checkResult("hm", 32'h0200, 32'h0200, 8'h28);
        acceptResult("hm");

        // Stalled consumer with an overrunning timestep_end and a spike during OUT.
        sendSpike(0);
        closeTimestep("ovr");
        checkResult("ovr", 32'h0480, 32'h0480, 8'h01);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                spike_valid = 1'b1;
                spike_addr = 12'd1;
                timestep_end = 1'b1;
            end
            step();
            spike_valid = 1'b0;
            timestep_end = 1'b0;
            checkOutput("ovrHoldValid", int'(out_valid), 1);
            checkOutput("ovrHoldSum", int'(out_sum), 32'h0480);
            checkOutput("ovrPulse", int'(overrun), (k == 2) ? 1 : 0);
            if (k == 2) checkOutput("ovrSpikeHit", int'(spike_hit), 1);
        end
        acceptResult("ovr");
        closeTimestep("roll");
        checkResult("roll", 32'h0130, 32'h0130, 8'h02);
        acceptResult("roll");

        // Same-cycle spike with timestep_end, then a rejected write during ACCUM.
        spike_valid = 1'b1;
        spike_addr = 12'd0;
        timestep_end = 1'b1;
        step();
        spike_valid = 1'b0;
        timestep_end = 1'b0;
        cfg_we = 1'b1;
        cfg_idx = 3'd0;
        cfg_src_addr = 12'd0;
        cfg_weight = 16'h7777;
        cfg_en = 1'b1;
        step();
        cfg_we = 1'b0;
        checkOutput("cfgErrAccum", int'(cfg_err), 1);
        step();
        checkOutput("cfgErrClear", int'(cfg_err), 0);
        waitValid(n);
        checkResult("same", 32'h0480, 32'h0480, 8'h01);
        acceptResult("same");
        sendSpike(0);
        closeTimestep("tblKeep");
        checkResult("tblKeep", 32'h0480, 32'h0480, 8'h01);
        acceptResult("tblKeep");

        // Saturation: the 16-bit instance clamps, the 24-bit one does not.
        for (int i = 0; i < 8; i++) writeEntry(i, i, 16'h7FFF, 1'b1);
        for (int i = 0; i < 8; i++) sendSpike(i);
        closeTimestep("satPos");
        checkResult("satPos", 262136, 32767, 8'hFF);
        acceptResult("satPos");
        for (int i = 0; i < 8; i++) writeEntry(i, i, 16'h8000, 1'b1);
        for (int i = 0; i < 8; i++) sendSpike(i);
        closeTimestep("satNeg");
        checkResult("satNeg", -262144, -32768, 8'hFF);
        acceptResult("satNeg");
        for (int i = 0; i < 7; i++) writeEntry(i, i, 16'h7FFF, 1'b1);
        for (int i = 0; i < 8; i++) sendSpike(i);
        closeTimestep("satMix");
        checkResult("satMix", 196601, -1, 8'hFF);
        acceptResult("satMix");

        // Reset in the middle of accumulation aborts and clears the table.
        sendSpike(0);
        timestep_end = 1'b1;
        step();
        timestep_end = 1'b0;
        step();
        step();
        RST_Mac = 1'b1;
        step();
        checkOutput("midRst_valid", int'(out_valid), 0);
        checkOutput("midRst_busy", int'(busy), 0);
        checkOutput("midRst_sum", int'(out_sum), 0);
        checkOutput("midRst_map", int'(out_spike_map), 0);
        checkOutput("midRst_pulses", int'({cfg_err, spike_hit, spike_miss, overrun}), 0);
        RST_Mac = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            checkOutput("midRst_noResult", int'(out_valid), 0);
        end
        sendSpike(0);
        checkOutput("clearedMiss", int'(spike_miss), 1);
        closeTimestep("postRst");
        checkResult("postRst", 0, 0, 8'h00);
        acceptResult("postRst");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
